// File: rtl/controle_multiciclo_if.sv
// Control bus between the multicycle MIPS main control FSM and its datapath.
// master: the control FSM (drives enables/selects, reads Opcode/Funct/Zero).
// slave : the datapath side (drives Opcode/Funct/Zero, reads the controls).
interface controle_multiciclo_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALUControle;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic       Invalida;
  logic [3:0] Estado;

  modport master (
    input  Opcode, Funct, Zero,
    output ALUControle, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCWrite, PCSource, Invalida, Estado
  );

  modport slave (
    output Opcode, Funct, Zero,
    input  ALUControle, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCWrite, PCSource, Invalida, Estado
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS main control FSM.
// Drives the ALU operation code and every datapath enable/select from the
// instruction Opcode/Funct fields and the ALU Zero flag. Outputs are decoded
// from the registered state (Moore), except PCWrite in BRANCH, which follows
// Zero, and Invalida/ALUControle in DECODE/EXECUTE, which follow the fields.
// Supported: lw, sw, beq, j, addi, R-type add/sub/and/or/nor/slt.
// Optional feature: define CONTROLE_BNE_EN to also accept bne (opcode 0x05).
// MEM_WAIT (0..15) adds that many extra cycles in MEMREAD/MEMWRITE.
module controle_multiciclo #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  controle_multiciclo_if.master   bus
);

  // State codes (also exported on Estado for debug)
  localparam logic [3:0] S_INICIO   = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECUTE  = 4'd7;
  localparam logic [3:0] S_RTYPEWB  = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_ADDIEX   = 4'd11;
  localparam logic [3:0] S_ADDIWB   = 4'd12;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  // ALUSrcB / PCSource selects
  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  // Last value of the wait counter before leaving a memory state; the
  // counter is 4 bits wide, so MEM_WAIT above 15 wraps.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  logic [3:0] state;
  logic [3:0] next_state;
  logic [3:0] wait_cnt;
  logic       wait_done;
  logic       opcode_ok;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic       mem_state;

  assign mem_state = (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign wait_done = (wait_cnt == WAIT_LAST);

  // Opcode legality check used to flag unsupported instructions in DECODE
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    opcode_ok = 1'b0;
    case (bus.Opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: opcode_ok = 1'b1;
`ifdef CONTROLE_BNE_EN
      OP_BNE: opcode_ok = 1'b1;
`endif
      default: opcode_ok = 1'b0;
    endcase
  end

  // R-type Funct to ALU operation; unknown Funct yields AND and a fault
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_AND;
    case (bus.Funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_NOR:  funct_alu = ALU_NOR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_INICIO: next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
`ifdef CONTROLE_BNE_EN
          OP_BNE:       next_state = S_BRANCH;
`endif
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDIEX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (bus.Opcode)
          OP_LW:   next_state = S_MEMREAD;
          OP_SW:   next_state = S_MEMWRITE;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMREAD:  next_state = wait_done ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = wait_done ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  next_state = funct_ok ? S_RTYPEWB : S_FETCH;
      S_RTYPEWB:  next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_ADDIEX:   next_state = S_ADDIWB;
      S_ADDIWB:   next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  // State register; reset parks the FSM in INICIO with all outputs low
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignments keep every register updating from
    // pre-edge values, so ordering between always_ff blocks cannot matter.
    if (!reset) begin
      state <= S_INICIO;
    end else begin
      state <= next_state;
    end
  end

  // Memory wait counter: zero on entry, counts while held, cleared on exit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
    end else if (mem_state && !wait_done) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  // Datapath controls decoded from the current state
  always_comb begin
    bus.ALUControle = ALU_AND;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_REG;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCSource    = PCS_ALU;
    bus.Invalida    = 1'b0;
    case (state)
      S_FETCH: begin
        bus.MemRead     = 1'b1;
        bus.IRWrite     = 1'b1;
        bus.ALUSrcB     = SRCB_FOUR;
        bus.ALUControle = ALU_ADD;
        bus.PCWrite     = 1'b1;
        bus.PCSource    = PCS_ALU;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded
        bus.ALUSrcB     = SRCB_IMMSH;
        bus.ALUControle = ALU_ADD;
        bus.Invalida    = !opcode_ok;
      end
      S_MEMADR: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = SRCB_IMM;
        bus.ALUControle = ALU_ADD;
      end
      S_MEMREAD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        bus.RegDst   = 1'b0;
      end
      S_MEMWRITE: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXECUTE: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = SRCB_REG;
        bus.ALUControle = funct_alu;
        bus.Invalida    = !funct_ok;
      end
      S_RTYPEWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = SRCB_REG;
        bus.ALUControle = ALU_SUB;
        bus.PCSource    = PCS_ALUOUT;
`ifdef CONTROLE_BNE_EN
        // Opcode is held through BRANCH, so it selects the taken condition
        bus.PCWrite     = (bus.Opcode == OP_BNE) ? !bus.Zero : bus.Zero;
`else
        bus.PCWrite     = bus.Zero;
`endif
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PCS_JUMP;
      end
      S_ADDIEX: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = SRCB_IMM;
        bus.ALUControle = ALU_ADD;
      end
      S_ADDIWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b0;
      end
      default: begin
        // INICIO and unused codes 13..15 keep every output at zero
      end
    endcase
  end

  assign bus.Estado = state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: a table of per-cycle
// {Opcode, Funct, Zero, expected outputs} records feeds a scoreboard that a
// monitor drains mid-cycle, followed by directed reset / wait-state sequences
// on a second instance built with MEM_WAIT=2.
module tb_controle_multiciclo;

  logic clock = 1'b0;
  logic reset;

  controle_multiciclo_if bus ();
  controle_multiciclo_if bus_w ();

  controle_multiciclo #(.MEM_WAIT(0)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  controle_multiciclo #(.MEM_WAIT(2)) u_dut_w (
    .clock (clock),
    .reset (reset),
    .bus   (bus_w)
  );

  assign bus_w.Opcode = bus.Opcode;
  assign bus_w.Funct  = bus.Funct;
  assign bus_w.Zero   = bus.Zero;

  always #5 clock = ~clock;

  // Packed view of all outputs:
  // Estado, ALUControle, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
  // RegDst, MemtoReg, RegWrite, PCWrite, PCSource, Invalida
  logic [21:0] obs;
  logic [21:0] obs_w;
  assign obs = {bus.Estado, bus.ALUControle, bus.ALUSrcA, bus.ALUSrcB,
                bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
                bus.MemtoReg, bus.RegWrite, bus.PCWrite, bus.PCSource,
                bus.Invalida};
  assign obs_w = {bus_w.Estado, bus_w.ALUControle, bus_w.ALUSrcA,
                  bus_w.ALUSrcB, bus_w.IorD, bus_w.MemRead, bus_w.MemWrite,
                  bus_w.IRWrite, bus_w.RegDst, bus_w.MemtoReg, bus_w.RegWrite,
                  bus_w.PCWrite, bus_w.PCSource, bus_w.Invalida};

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic [21:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [21:0] sb[$];
  int          total = 0;
  int          bad   = 0;
  int          mon_idx = 0;
  logic [21:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] mk(input int est, input int aluc,
                                     input int srca, input int srcb,
                                     input int iord, input int mr,
                                     input int mw, input int irw,
                                     input int rdst, input int m2r,
                                     input int rw, input int pcw,
                                     input int pcs, input int inv);
    return {4'(est), 4'(aluc), 1'(srca), 2'(srcb), 1'(iord), 1'(mr),
            1'(mw), 1'(irw), 1'(rdst), 1'(m2r), 1'(rw), 1'(pcw), 2'(pcs),
            1'(inv)};
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic [21:0] exp);
    vec_t v;
    v.op   = op;
    v.fn   = fn;
    v.zero = z;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  // Monitor: compare one scoreboard entry per cycle, mid-cycle
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check($sformatf("vec%0d", mon_idx), {10'd0, obs}, {10'd0, mon_exp});
        mon_idx++;
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  int          fns[6]   = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h27, 32'h2A};
  int          alus[6]  = '{2, 6, 0, 1, 12, 7};
  int          w_est[8] = '{1, 2, 3, 4, 4, 4, 5, 1};
  int          w_mr[8]  = '{2, 0, 0, 3, 3, 3, 0, 2};
  int          w_m2r[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int          m_est[8] = '{1, 2, 3, 4, 5, 1, 2, 3};

  logic [21:0] e_fetch, e_decode, e_decode_bad, e_memadr, e_memrd, e_memwb;
  logic [21:0] e_memwr, e_rwb, e_jump, e_addiex, e_addiwb;

  initial begin
    //                est alu sA sB io mr mw ir rd m2 rw pw ps inv
    e_fetch      = mk(1,  2,  0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    e_decode     = mk(2,  2,  0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_decode_bad = mk(2,  2,  0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    e_memadr     = mk(3,  2,  1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_memrd      = mk(4,  0,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    e_memwb      = mk(5,  0,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    e_memwr      = mk(6,  0,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    e_rwb        = mk(8,  0,  0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    e_jump       = mk(10, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    e_addiex     = mk(11, 2,  1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_addiwb     = mk(12, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // lw with Zero high throughout: Zero must not matter outside BRANCH
    add(6'h23, 6'h00, 1'b1, e_fetch);
    add(6'h23, 6'h00, 1'b1, e_decode);
    add(6'h23, 6'h00, 1'b1, e_memadr);
    add(6'h23, 6'h00, 1'b1, e_memrd);
    add(6'h23, 6'h00, 1'b1, e_memwb);
    // sw
    add(6'h2B, 6'h00, 1'b0, e_fetch);
    add(6'h2B, 6'h00, 1'b0, e_decode);
    add(6'h2B, 6'h00, 1'b0, e_memadr);
    add(6'h2B, 6'h00, 1'b0, e_memwr);
    // R-type, every supported Funct
    for (int i = 0; i < 6; i++) begin
      add(6'h00, 6'(fns[i]), 1'b1, e_fetch);
      add(6'h00, 6'(fns[i]), 1'b1, e_decode);
      add(6'h00, 6'(fns[i]), 1'b1,
          mk(7, alus[i], 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(6'h00, 6'(fns[i]), 1'b1, e_rwb);
    end
    // addi
    add(6'h08, 6'h00, 1'b0, e_fetch);
    add(6'h08, 6'h00, 1'b0, e_decode);
    add(6'h08, 6'h00, 1'b0, e_addiex);
    add(6'h08, 6'h00, 1'b0, e_addiwb);
    // beq taken (Zero low before BRANCH, high in BRANCH)
    add(6'h04, 6'h00, 1'b0, e_fetch);
    add(6'h04, 6'h00, 1'b0, e_decode);
    add(6'h04, 6'h00, 1'b1, mk(9, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    // beq not taken (Zero high before BRANCH, low in BRANCH)
    add(6'h04, 6'h00, 1'b1, e_fetch);
    add(6'h04, 6'h00, 1'b1, e_decode);
    add(6'h04, 6'h00, 1'b0, mk(9, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // j, with Zero low: PCWrite is unconditional here
    add(6'h02, 6'h00, 1'b0, e_fetch);
    add(6'h02, 6'h00, 1'b0, e_decode);
    add(6'h02, 6'h00, 1'b0, e_jump);
    // unsupported opcode: Invalida in DECODE, straight back to FETCH
    add(6'h3F, 6'h00, 1'b0, e_fetch);
    add(6'h3F, 6'h00, 1'b0, e_decode_bad);
    // unsupported Funct: Invalida in EXECUTE with ALUControle=AND
    add(6'h00, 6'h3F, 1'b0, e_fetch);
    add(6'h00, 6'h3F, 1'b0, e_decode);
    add(6'h00, 6'h3F, 1'b0, mk(7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // bne
`ifdef CONTROLE_BNE_EN
    add(6'h05, 6'h00, 1'b1, e_fetch);
    add(6'h05, 6'h00, 1'b1, e_decode);
    add(6'h05, 6'h00, 1'b0, mk(9, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
`else
    add(6'h05, 6'h00, 1'b0, e_fetch);
    add(6'h05, 6'h00, 1'b0, e_decode_bad);
`endif
    add(6'h02, 6'h00, 1'b0, e_fetch);

    // ---- Reset held low for three cycles, then released ----
    bus.Opcode = 6'h00;
    bus.Funct  = 6'h00;
    bus.Zero   = 1'b1;
    reset      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #3;
      check($sformatf("reset_outs%0d", i), {10'd0, obs}, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    #3;
    check("release_estado", {28'd0, bus.Estado}, 32'd0);

    // ---- Table-driven run through the scoreboard ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      bus.Opcode = vecs[i].op;
      bus.Funct  = vecs[i].fn;
      bus.Zero   = vecs[i].zero;
      sb.push_back(vecs[i].exp);
    end
    for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge clock);
    #4;
    if (sb.size() != 0) check("sb_drain", sb.size(), 32'd0);

    // ---- lw on both instances: MEM_WAIT=2 holds MEMREAD three cycles ----
    @(negedge clock);
    reset      = 1'b0;
    bus.Opcode = 6'h23;
    bus.Funct  = 6'h00;
    bus.Zero   = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #3;
    check("w_release_estado", {28'd0, bus_w.Estado}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      #3;
      check($sformatf("w_estado%0d", i), {28'd0, bus_w.Estado}, 32'(w_est[i]));
      check($sformatf("w_memrd_iord%0d", i),
            {30'd0, bus_w.MemRead, bus_w.IorD}, 32'(w_mr[i]));
      check($sformatf("w_memtoreg%0d", i), {31'd0, bus_w.MemtoReg},
            32'(w_m2r[i]));
      check($sformatf("m0_estado%0d", i), {28'd0, bus.Estado}, 32'(m_est[i]));
    end

    // ---- Reset asserted in the middle of MEMWRITE ----
    @(negedge clock);
    reset      = 1'b0;
    bus.Opcode = 6'h2B;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);        // FETCH, DECODE, MEMADR
    @(negedge clock);                   // MEMWRITE
    #1;
    check("memwrite_before_rst", {31'd0, bus.MemWrite}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("memwrite_async_drop", {31'd0, bus.MemWrite}, 32'd0);
    check("outs_async_zero", {10'd0, obs}, 32'd0);
    check("outs_async_zero_w", {10'd0, obs_w}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #3;
    check("rst2_estado0", {28'd0, bus.Estado}, 32'd0);
    @(negedge clock);
    #3;
    check("rst2_estado1", {28'd0, bus.Estado}, 32'd1);
    check("rst2_fetch_outs", {10'd0, obs}, {10'd0, e_fetch});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
